// File: rtl/cu_pkg.sv
// Shared types and constants for the parametrised control unit:
// state encoding, instruction format codes and the operand-mux immediate code.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_STORE = 3'd5
  } state_t;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_J   = 2'b10;
  localparam logic [1:0] FMT_ILL = 2'b11;

  // The operand mux selects the immediate with the code just past the last register.
  function automatic int unsigned mux_imm_code(input int unsigned reg_bits);
    return 32'd1 << reg_bits;
  endfunction

endpackage

// File: rtl/reg_onehot_decoder.sv
// Turns a register index into a one-hot register-file write vector, gated by en.
module reg_onehot_decoder #(
  parameter int NUM_REGS = 8
) (
  input  logic                        en,
  input  logic [$clog2(NUM_REGS)-1:0] idx,
  output logic [NUM_REGS-1:0]         onehot
);

  localparam int IDX_W = $clog2(NUM_REGS);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/control_unit_param.sv
// Instruction sequencer: FETCH, LOAD, EXEC, optional ALU WAIT, STORE, with a
// start/busy/done handshake, ALU timeout and illegal-format detection.
module control_unit_param
  import cu_pkg::*;
#(
  parameter int NUM_REGS     = 8,
  parameter int INSTR_W      = 16,
  parameter int DATA_W       = 16,
  parameter int SIGN_EXT_IMM = 0,
  parameter int MAX_WAIT     = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [INSTR_W-1:0]            instruction,
  input  logic                          alu_ready,
  output logic                          busy,
  output logic                          en_i,
  output logic                          en_s,
  output logic                          en_c,
  output logic [NUM_REGS-1:0]           reg_en,
  output logic [$clog2(NUM_REGS):0]     mux_sel,
  output logic [2:0]                    sel,
  output logic [DATA_W-1:0]             imm_val,
  output logic                          done,
  output logic                          error
);

  localparam int REG_BITS = $clog2(NUM_REGS);
  localparam int IMM_W    = INSTR_W - REG_BITS - 5;
  localparam int MUX_W    = REG_BITS + 1;
  localparam logic [MUX_W-1:0] MUX_IMM  = MUX_W'(mux_imm_code(REG_BITS));
  localparam logic [MUX_W-1:0] MUX_IDLE = '1;
  localparam logic [7:0]       WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t            state_reg, state_next;
  logic [7:0]        wait_cnt_reg, wait_cnt_next;
  logic              err_reg, err_next;

  logic [1:0]          fmt;
  logic [2:0]          alu;
  logic [REG_BITS-1:0] rx, ry;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   imm_ext;
  logic                is_ill, is_imm;

  assign fmt    = instruction[1:0];
  assign alu    = instruction[4:2];
  assign rx     = instruction[INSTR_W-1 -: REG_BITS];
  assign ry     = instruction[INSTR_W-REG_BITS-1 -: REG_BITS];
  assign imm    = instruction[INSTR_W-REG_BITS-1:5];
  assign is_ill = (fmt == FMT_ILL);
  assign is_imm = (fmt == FMT_I);

  generate
    if (IMM_W >= DATA_W) begin : g_imm_trunc
      assign imm_ext = imm[DATA_W-1:0];
    end else if (SIGN_EXT_IMM != 0) begin : g_imm_sext
      assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    end else begin : g_imm_zext
      assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    err_next      = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          err_next   = 1'b0;
        end
      end
      ST_FETCH: state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_EXEC;
      ST_EXEC: begin
        if (is_ill) begin
          err_next   = 1'b1;
          state_next = ST_STORE;
        end else if (alu_ready) begin
          state_next = ST_STORE;
        end else begin
          state_next    = ST_WAIT;
          wait_cnt_next = '0;
        end
      end
      ST_WAIT: begin
        wait_cnt_next = wait_cnt_reg + 8'd1;
        if (alu_ready) begin
          state_next = ST_STORE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // ALU never answered: retire the instruction without a write.
          err_next   = 1'b1;
          state_next = ST_STORE;
        end
      end
      ST_STORE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg != ST_IDLE);
    en_i    = 1'b0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    mux_sel = MUX_IDLE;
    sel     = 3'd0;
    imm_val = '0;
    done    = 1'b0;
    error   = 1'b0;
    case (state_reg)
      ST_FETCH: en_i = 1'b1;
      ST_LOAD: begin
        en_s    = 1'b1;
        mux_sel = {1'b0, rx};
      end
      ST_EXEC, ST_WAIT: begin
        if (!is_ill) begin
          sel = alu;
          if (is_imm) begin
            mux_sel = MUX_IMM;
            imm_val = imm_ext;
          end else begin
            mux_sel = {1'b0, ry};
          end
          en_c = (state_reg == ST_EXEC) || alu_ready;
        end
      end
      ST_STORE: begin
        done  = 1'b1;
        error = err_reg;
      end
      default: ;
    endcase
  end

  reg_onehot_decoder #(.NUM_REGS(NUM_REGS)) u_dec (
    .en     ((state_reg == ST_STORE) && !err_reg),
    .idx    (rx),
    .onehot (reg_en)
  );

endmodule
